// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control unit: states, opcodes,
// ALU operation selects and the bundled control-output struct.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_ANDI  = 3'b010;
  localparam logic [2:0] OP_ORI   = 3'b011;
  localparam logic [2:0] OP_SLTI  = 3'b100;
  localparam logic [2:0] OP_LW    = 3'b101;
  localparam logic [2:0] OP_SW    = 3'b110;
  localparam logic [2:0] OP_BEQ   = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] ALUB_REG = 2'b00;
  localparam logic [1:0] ALUB_ONE = 2'b01;
  localparam logic [1:0] ALUB_IMM = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic logic is_itype(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Purely combinational control-output decode from the current state, opcode,
// ALU zero flag and memory handshake. Holds no state.
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     st,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (st)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        // IR and PC only commit in the cycle the fetch completes.
        ctrl.ir_we     = mem_ready;
        ctrl.pc_we     = mem_ready;
        ctrl.pc_src    = 1'b0;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        if (opcode == OP_RTYPE) begin
          ctrl.alu_src_b = ALUB_REG;
          ctrl.alu_op    = ALUOP_RTYPE;
        end else if (opcode == OP_BEQ) begin
          ctrl.alu_src_b = ALUB_REG;
          ctrl.alu_op    = ALUOP_SUB;
          ctrl.pc_src    = 1'b1;
          ctrl.pc_we     = zero;
        end else if (is_mem_op(opcode)) begin
          ctrl.alu_src_b = ALUB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end else begin
          ctrl.alu_src_b = ALUB_IMM;
          ctrl.alu_op    = ALUOP_ITYPE;
        end
      end
      ST_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.mem_we  = (opcode == OP_SW);
      end
      ST_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = (opcode == OP_RTYPE);
        ctrl.mem_to_reg = (opcode == OP_LW);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on
// the shared memory port and counts retired instructions.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  // Memory handshake: a request is held with stable address/we until the
  // cycle mem_ready is sampled high; that cycle completes the access.
  state_t           st, st_nxt;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_FETCH;
      retired_q <= '0;
    end else begin
      st <= st_nxt;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    st_nxt = st;
    retire = 1'b0;
    unique case (st)
      ST_FETCH:  if (mem_ready) st_nxt = ST_DECODE;
      ST_DECODE: st_nxt = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_BEQ) begin
          st_nxt = ST_FETCH;
          retire = 1'b1;
        end else if (is_mem_op(opcode)) begin
          st_nxt = ST_MEM;
        end else begin
          st_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            st_nxt = ST_FETCH;
            retire = 1'b1;
          end else begin
            st_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        st_nxt = ST_FETCH;
        retire = 1'b1;
      end
      default: st_nxt = ST_FETCH;
    endcase
  end

  ctrl_out_decode u_dec (
    .st        (st),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign pc_src     = ctrl.pc_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_we     = ctrl.reg_we;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign state      = st;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors
// are queued when an instruction is scheduled and compared as it executes.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int W     = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic             reg_we, reg_dst, mem_to_reg;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_ret;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic         z_q[$];

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .state      (state),
    .retired    (retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs_vec();
    return {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
            alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg};
  endfunction

  // Expected outputs written straight from the state/opcode table.
  function automatic logic [W-1:0] exp_vec(input logic [2:0] st, input logic [2:0] op,
                                           input logic rdy, input logic z);
    logic mreq, mwe, io, irw, pcw, pcs, asa, rwe, rdst, m2r;
    logic [1:0] asb, aop;
    {mreq, mwe, io, irw, pcw, pcs, asa, rwe, rdst, m2r} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      3'd0: begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      3'd1: asb = 2'b10;
      3'd2: begin
        asa = 1;
        if (op == 3'b000)      begin asb = 2'b00; aop = 2'b10; end
        else if (op == 3'b111) begin asb = 2'b00; aop = 2'b01; pcs = 1; pcw = z; end
        else if (op == 3'b101 || op == 3'b110) begin asb = 2'b10; aop = 2'b00; end
        else                   begin asb = 2'b10; aop = 2'b11; end
      end
      3'd3: begin mreq = 1; io = 1; mwe = (op == 3'b110); end
      3'd4: begin rwe = 1; rdst = (op == 3'b000); m2r = (op == 3'b101); end
      default: ;
    endcase
    return {st, mreq, mwe, io, irw, pcw, pcs, asa, asb, aop, rwe, rdst, m2r};
  endfunction

  // driver: schedule one cycle of stimulus together with its expected outputs
  task automatic sched(input logic [2:0] st, input logic [2:0] op, input logic rdy, input logic z);
    rdy_q.push_back(rdy);
    z_q.push_back(z);
    exp_q.push_back(exp_vec(st, op, rdy, z));
  endtask

  task automatic run_instr(input string name, input logic [2:0] op, input int fw,
                           input int mw, input logic z);
    int irw = 0;
    int cyc = 0;
    logic [W-1:0] exp, obs;
    for (int i = 0; i < fw; i++) sched(3'd0, op, 1'b0, 1'($urandom_range(0, 1)));
    sched(3'd0, op, 1'b1, 1'($urandom_range(0, 1)));
    sched(3'd1, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    sched(3'd2, op, 1'($urandom_range(0, 1)), z);
    if (op == 3'b101 || op == 3'b110) begin
      for (int i = 0; i < mw; i++) sched(3'd3, op, 1'b0, 1'($urandom_range(0, 1)));
      sched(3'd3, op, 1'b1, 1'($urandom_range(0, 1)));
      if (op == 3'b101) sched(3'd4, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end else if (op != 3'b111) begin
      sched(3'd4, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      opcode    = op;
      mem_ready = rdy_q.pop_front();
      zero      = z_q.pop_front();
      #1;
      exp = exp_q.pop_front();
      obs = obs_vec();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, exp);
      end
      if (ir_we === 1'b1) irw++;
      cyc++;
    end
    total++;
    if (irw != 1) begin
      bad++;
      $display("FAIL %s ir_we pulses: got %0d expected 1", name, irw);
    end
    @(posedge clk);
    #1;
    exp_ret = exp_ret + 1'b1;
    mem_ready = 1'b0;
    total++;
    if (retired !== exp_ret || state !== 3'd0) begin
      bad++;
      $display("FAIL %s retire: retired=%0d state=%0d expected retired=%0d state=0",
               name, retired, state, exp_ret);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (state !== 3'd0 || retired !== '0 || mem_req !== 1'b1 || iord !== 1'b0 ||
        reg_we !== 1'b0 || ir_we !== 1'b0 || pc_we !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL %s: state=%0d retired=%0d mem_req=%b iord=%b reg_we=%b ir_we=%b pc_we=%b mem_we=%b expected 0 0 1 0 0 0 0 0",
               name, state, retired, mem_req, iord, reg_we, ir_we, pc_we, mem_we);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_reset_outputs("reset_assert");
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    opcode = 3'b000;
    zero = 1'b0;
    mem_ready = 1'b0;
    exp_ret = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset_initial");
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    run_instr("rtype", 3'b000, 0, 0, 1'b0);
  endtask

  task automatic test_lw_waits();
    run_instr("lw_waits", 3'b101, 2, 3, 1'b0);
  endtask

  task automatic test_sw();
    run_instr("sw", 3'b110, 1, 1, 1'b0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 3'b111, 0, 0, 1'b1);
    run_instr("beq_not_taken", 3'b111, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_mem();
    // walk an LW into a stalled MEM, then pull reset
    @(negedge clk); opcode = 3'b101; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (state !== 3'd3 || mem_req !== 1'b1 || iord !== 1'b1) begin
      bad++;
      $display("FAIL mid_mem_reach: state=%0d mem_req=%b iord=%b expected 3 1 1", state, mem_req, iord);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_mem");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_mem_hold");
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) run_instr("itype_wrap", 3'b011, $urandom_range(0, 1), 0, 1'b0);
    total++;
    if (retired !== 4'd1) begin
      bad++;
      $display("FAIL wrap_count: got %0d expected 1", retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      run_instr("mixed", op, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_sw();
    test_beq();
    test_reset_mid_mem();
    test_rtype();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control unit for the 16-bit CPU. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath selects and write enables, and issues the 2-bit `alu_op` consumed by the ALU control decoder. Handshakes with a shared instruction/data memory port that may insert wait states. Counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 3: IR[15:13], valid from DECODE onward.
- `zero` input 1: ALU zero flag, sampled in EXEC.
- `mem_ready` input 1: memory accepts or completes the current access this cycle.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: store (qualifies `mem_req`).
- `iord` output 1: address select; 0 = PC, 1 = ALUOut.
- `ir_we` output 1: instruction register load.
- `pc_we` output 1: PC write.
- `pc_src` output 1: 0 = ALU result (PC+1), 1 = ALUOut (branch target).
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = register B, 01 = constant 1, 10 = sign-extended immediate.
- `alu_op` output 2: 00 add, 01 sub, 10 R-type (funct), 11 I-type (opcode).
- `reg_we` output 1: register-file write.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `mem_to_reg` output 1: 0 = ALUOut, 1 = MDR.
- `state` output 3: current state, for debug.
- `retired` output CNT_W: retired-instruction count.

## Operation
- Opcode map: 000 R-type; 001, 010, 011, 100 I-type ALU; 101 LW; 110 SW; 111 BEQ. All eight codes are legal.
- Control outputs are a combinational function of `state` and `opcode`. Any output not listed for a state is 0.
- **FETCH**
  - Asserts `mem_req`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - When `mem_ready`=1: also asserts `ir_we` and `pc_we` (`pc_src`=0), then goes to DECODE.
  - When `mem_ready`=0: stays in FETCH with `ir_we` and `pc_we` held at 0.
- **DECODE**
  - `alu_src_a`=0, `alu_src_b`=10, `alu_op`=00 (branch target to ALUOut). Always goes to EXEC.
- **EXEC**
  - R-type: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, then WB.
  - I-type: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11, then WB.
  - LW/SW: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, then MEM.
  - BEQ: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=1, `pc_we`=`zero`; instruction retires, then FETCH.
- **MEM**
  - Asserts `mem_req`, `iord`=1, `mem_we`=(opcode==SW).
  - Stays in MEM until `mem_ready`=1.
  - Then: LW goes to WB; SW retires and goes to FETCH.
- **WB**
  - `reg_we`=1.
  - R-type: `reg_dst`=1. I-type: `reg_dst`=0. LW: `reg_dst`=0, `mem_to_reg`=1.
  - Instruction retires, then FETCH.
- `retired` increments by 1 on each retirement and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (async assert, synchronous release): `state`=FETCH and `retired`=0. All outputs are their FETCH values with `mem_ready`=0, so `mem_req`=1 and every write enable is 0.
- Minimum cycles per instruction with zero wait states:
  - BEQ 3
  - R-type, I-type, SW 4
  - LW 5
- Each cycle `mem_ready` is low in FETCH or MEM adds exactly one cycle.
- `mem_req` stays high and address/`mem_we` stay stable until the cycle in which `mem_ready` is sampled high.
- A `mem_ready` pulse in any state other than FETCH or MEM is ignored.
- `rst_n` low mid-instruction (including during a memory wait) aborts the instruction immediately: no retirement and no write enable asserted.
- `zero` is used only in the BEQ EXEC cycle.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
  - opcode constants
  - `alu_op` constants (ALUOP_ADD, SUB, RTYPE, ITYPE)
  - `alu_src_b` encodings
- Optional sub-module `ctrl_out_decode`: purely combinational (`state`, `opcode`, `zero`, `mem_ready`) → control outputs. It keeps the FSM register and counter separate from output decode.

## Test plan
- Reset during MEM of an LW with `mem_ready`=0 → next cycle `state`=FETCH, `retired`=0, `reg_we`=0, `mem_req`=1 with `iord`=0.
- R-type (000), `mem_ready` tied 1 → 4 cycles; `alu_op` is 00 in FETCH, 10 in EXEC; `reg_we`=1 and `reg_dst`=1 in WB; `retired` goes 0→1.
- LW (101) with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM → 10 cycles total; `ir_we` pulses exactly once; `mem_to_reg`=1 in WB.
- SW (110) → `mem_we`=1 only in MEM; `reg_we` never asserted; retires after MEM.
- BEQ (111) with `zero`=1 → `pc_we`=1 and `pc_src`=1 in EXEC, 3 cycles. With `zero`=0 → `pc_we`=0 in EXEC.
- CNT_W=4: retire 17 I-type (011) instructions → `retired`=1 after wrap; `alu_op`=11 in every EXEC.
